// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order reorder buffer and single-retire commit engine
// Flag storage and the flag-write port are built only when PJ_ROB_FLAG_COMMIT_EN is defined.
module rob_commit #(
    parameter int NUM_PHYS_REG = 128,
    parameter int NUM_FLAGS    = 4,
    parameter int NUM_FU       = 4,
    parameter int ROB_DEPTH    = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  disp_v_i,
    output logic                                  disp_ready_o,
    input  logic                                  disp_has_dest_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0]       disp_old_phys_i,
    input  logic [NUM_FLAGS-1:0]                  disp_flag_mask_i,
    output logic [$clog2(ROB_DEPTH)-1:0]          disp_tag_o,
    input  logic [NUM_FU-1:0]                     cmpl_v_i,
    input  logic [NUM_FU*$clog2(ROB_DEPTH)-1:0]   cmpl_tag_i,
    input  logic [NUM_FU*NUM_FLAGS-1:0]           cmpl_flags_i,
    input  logic                                  flush_i,
    output logic                                  rob_phys_valid_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0]       rob_phys_reg_cl_o,
    output logic                                  rob_flag_valid_o,
    output logic [2*NUM_FLAGS-1:0]                rob_flag_o,
    output logic                                  commit_v_o,
    output logic [$clog2(ROB_DEPTH)-1:0]          commit_tag_o,
    output logic                                  empty_o
);
    localparam int TW = $clog2(ROB_DEPTH);
    localparam int PW = $clog2(NUM_PHYS_REG);

    logic [TW:0]                   head_q, head_d, tail_q, tail_d;
    logic [ROB_DEPTH-1:0]          valid_q, valid_d, done_q, done_d;
    logic [ROB_DEPTH-1:0]          has_dest_q, has_dest_d;
    logic [ROB_DEPTH-1:0][PW-1:0]  old_phys_q, old_phys_d;
`ifdef PJ_ROB_FLAG_COMMIT_EN
    logic [ROB_DEPTH-1:0][NUM_FLAGS-1:0] mask_q, mask_d, flags_q, flags_d;
    logic                          flag_valid_q;
    logic [2*NUM_FLAGS-1:0]        flag_q;
`else
    logic                          unused_flag_inputs;
`endif
    logic                          commit_v_q, phys_valid_q;
    logic [TW-1:0]                 commit_tag_q;
    logic [PW-1:0]                 phys_reg_q;

    logic [TW-1:0] head_idx, tail_idx;
    logic          full, disp_go, commit_go;

    assign head_idx  = head_q[TW-1:0];
    assign tail_idx  = tail_q[TW-1:0];
    assign full      = (head_idx == tail_idx) && (head_q[TW] != tail_q[TW]);
    assign disp_go   = disp_v_i && !full;
    assign commit_go = valid_q[head_idx] && done_q[head_idx];

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        valid_d    = valid_q;
        done_d     = done_q;
        has_dest_d = has_dest_q;
        old_phys_d = old_phys_q;
`ifdef PJ_ROB_FLAG_COMMIT_EN
        mask_d     = mask_q;
        flags_d    = flags_q;
`endif
        // Walk FUs from highest to lowest so the lowest index writes last and wins a tag collision.
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (cmpl_v_i[i] && valid_q[cmpl_tag_i[i*TW +: TW]]) begin
                done_d[cmpl_tag_i[i*TW +: TW]] = 1'b1;
`ifdef PJ_ROB_FLAG_COMMIT_EN
                flags_d[cmpl_tag_i[i*TW +: TW]] = cmpl_flags_i[i*NUM_FLAGS +: NUM_FLAGS];
`endif
            end
        end
        if (commit_go) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + (TW+1)'(1);
        end
        if (disp_go) begin
            valid_d[tail_idx]    = 1'b1;
            done_d[tail_idx]     = 1'b0;
            has_dest_d[tail_idx] = disp_has_dest_i;
            old_phys_d[tail_idx] = disp_old_phys_i;
`ifdef PJ_ROB_FLAG_COMMIT_EN
            mask_d[tail_idx]     = disp_flag_mask_i;
`endif
            tail_d               = tail_q + (TW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            valid_q      <= '0;
            done_q       <= '0;
            commit_v_q   <= 1'b0;
            commit_tag_q <= '0;
            phys_valid_q <= 1'b0;
            phys_reg_q   <= '0;
`ifdef PJ_ROB_FLAG_COMMIT_EN
            flag_valid_q <= 1'b0;
            flag_q       <= '0;
`endif
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            commit_v_q   <= commit_go;
            commit_tag_q <= commit_go ? head_idx : '0;
            phys_valid_q <= commit_go && has_dest_q[head_idx];
            phys_reg_q   <= (commit_go && has_dest_q[head_idx]) ? old_phys_q[head_idx] : '0;
`ifdef PJ_ROB_FLAG_COMMIT_EN
            flag_valid_q <= commit_go;
            flag_q       <= commit_go ? {mask_q[head_idx], flags_q[head_idx]} : '0;
`endif
        end
    end

    // Payload fields are only meaningful while valid is set, so they need no reset.
    always_ff @(posedge clk_i) begin
        has_dest_q <= has_dest_d;
        old_phys_q <= old_phys_d;
`ifdef PJ_ROB_FLAG_COMMIT_EN
        mask_q     <= mask_d;
        flags_q    <= flags_d;
`endif
    end

    assign disp_ready_o      = !full;
    assign disp_tag_o        = tail_idx;
    assign empty_o           = (head_q == tail_q);
    assign commit_v_o        = commit_v_q;
    assign commit_tag_o      = commit_tag_q;
    assign rob_phys_valid_o  = phys_valid_q;
    assign rob_phys_reg_cl_o = phys_reg_q;
`ifdef PJ_ROB_FLAG_COMMIT_EN
    assign rob_flag_valid_o  = flag_valid_q;
    assign rob_flag_o        = flag_q;
`else
    assign unused_flag_inputs = ^{cmpl_flags_i, disp_flag_mask_i};
    assign rob_flag_valid_o  = 1'b0;
    assign rob_flag_o        = '0;
`endif
endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - table-driven directed bench for rob_commit
// Flag expectations follow PJ_ROB_FLAG_COMMIT_EN.
module tb_rob_commit;
`ifdef PJ_ROB_FLAG_COMMIT_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        disp_v_i = 1'b0;
    logic        disp_ready_o;
    logic        disp_has_dest_i = 1'b0;
    logic [6:0]  disp_old_phys_i = '0;
    logic [3:0]  disp_flag_mask_i = '0;
    logic [3:0]  disp_tag_o;
    logic [3:0]  cmpl_v_i = '0;
    logic [15:0] cmpl_tag_i = '0;
    logic [15:0] cmpl_flags_i = '0;
    logic        flush_i = 1'b0;
    logic        rob_phys_valid_o;
    logic [6:0]  rob_phys_reg_cl_o;
    logic        rob_flag_valid_o;
    logic [7:0]  rob_flag_o;
    logic        commit_v_o;
    logic [3:0]  commit_tag_o;
    logic        empty_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk_i(clk), .reset_i(reset_i),
        .disp_v_i(disp_v_i), .disp_ready_o(disp_ready_o),
        .disp_has_dest_i(disp_has_dest_i), .disp_old_phys_i(disp_old_phys_i),
        .disp_flag_mask_i(disp_flag_mask_i), .disp_tag_o(disp_tag_o),
        .cmpl_v_i(cmpl_v_i), .cmpl_tag_i(cmpl_tag_i), .cmpl_flags_i(cmpl_flags_i),
        .flush_i(flush_i),
        .rob_phys_valid_o(rob_phys_valid_o), .rob_phys_reg_cl_o(rob_phys_reg_cl_o),
        .rob_flag_valid_o(rob_flag_valid_o), .rob_flag_o(rob_flag_o),
        .commit_v_o(commit_v_o), .commit_tag_o(commit_tag_o), .empty_o(empty_o)
    );

    typedef struct {
        logic rst; logic fl; logic dv; logic dh; logic [6:0] dphys; logic [3:0] dmask;
        logic [3:0] cv; logic [15:0] ctag; logic [15:0] cflags;
        logic ev; logic [3:0] etag; logic epv; logic [6:0] ephys; logic efv; logic [7:0] eflag;
        logic eempty; logic eready; logic [3:0] edtag;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic fl, input logic dv, input logic dh,
        input logic [6:0] dphys, input logic [3:0] dmask,
        input logic [3:0] cv, input logic [15:0] ctag, input logic [15:0] cflags,
        input logic ev, input logic [3:0] etag, input logic epv, input logic [6:0] ephys,
        input logic efv, input logic [7:0] eflag,
        input logic eempty, input logic eready, input logic [3:0] edtag);
        vec_t v;
        v.rst = rst; v.fl = fl; v.dv = dv; v.dh = dh; v.dphys = dphys; v.dmask = dmask;
        v.cv = cv; v.ctag = ctag; v.cflags = cflags;
        v.ev = ev; v.etag = etag; v.epv = epv; v.ephys = ephys; v.efv = efv; v.eflag = eflag;
        v.eempty = eempty; v.eready = eready; v.edtag = edtag;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s: got %0h want %0h", idx, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check the outputs just after the edge that consumed them.
    task automatic run_vec(input vec_t v, input int idx);
        reset_i = v.rst; flush_i = v.fl;
        disp_v_i = v.dv; disp_has_dest_i = v.dh; disp_old_phys_i = v.dphys; disp_flag_mask_i = v.dmask;
        cmpl_v_i = v.cv; cmpl_tag_i = v.ctag; cmpl_flags_i = v.cflags;
        @(posedge clk);
        #1;
        chk("commit_v", idx, 32'(commit_v_o), 32'(v.ev));
        chk("commit_tag", idx, 32'(commit_tag_o), 32'(v.etag));
        chk("phys_valid", idx, 32'(rob_phys_valid_o), 32'(v.epv));
        chk("phys_reg", idx, 32'(rob_phys_reg_cl_o), 32'(v.ephys));
        chk("flag_valid", idx, 32'(rob_flag_valid_o), 32'(FLAG_EN ? v.efv : 1'b0));
        chk("flag", idx, 32'(rob_flag_o), 32'(FLAG_EN ? v.eflag : 8'h00));
        chk("empty", idx, 32'(empty_o), 32'(v.eempty));
        chk("disp_ready", idx, 32'(disp_ready_o), 32'(v.eready));
        chk("disp_tag", idx, 32'(disp_tag_o), 32'(v.edtag));
    endtask

    vec_t tbl[$];

    initial begin
        // rst fl dv dh dphys dmask | cv ctag cflags | ev etag epv ephys efv eflag | empty ready dtag
        tbl.push_back(mk(1,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0));
        tbl.push_back(mk(0,0,1,1,7'h25,4'hC, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd1));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0100,16'h0000,16'h0300, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd1));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd0,1,7'h25,1,8'hC3, 1,1,4'd1));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd1));
        // out-of-order completion 2,1,0
        tbl.push_back(mk(1,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0));
        tbl.push_back(mk(0,0,1,1,7'h10,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd1));
        tbl.push_back(mk(0,0,1,1,7'h11,4'hF, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd2));
        tbl.push_back(mk(0,0,1,1,7'h12,4'h5, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0001,16'h0002,16'h0001, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0010,16'h0010,16'h0020, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b1000,16'h0000,16'h4000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd0,1,7'h10,1,8'h04, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd1,1,7'h11,1,8'hF2, 0,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd2,1,7'h12,1,8'h51, 1,1,4'd3));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd3));
        // no-dest entry, invalid-tag completion, FU collision on tag 5
        tbl.push_back(mk(0,0,1,0,7'h55,4'h9, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd4));
        tbl.push_back(mk(0,0,1,1,7'h7F,4'h3, 4'b0010,16'h0090,16'h00F0, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd5));
        tbl.push_back(mk(0,0,1,1,7'h33,4'h0, 4'b0101,16'h0403,16'h0806, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd6));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b1001,16'h5005,16'h500A, 1,4'd3,0,7'h00,1,8'h96, 0,1,4'd6));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd4,1,7'h7F,1,8'h38, 0,1,4'd6));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd5,1,7'h33,1,8'h0A, 1,1,4'd6));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd6));
        // six pending entries, then flush with a ready-to-commit head
        tbl.push_back(mk(0,0,1,1,7'h01,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd7));
        tbl.push_back(mk(0,0,1,1,7'h02,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd8));
        tbl.push_back(mk(0,0,1,1,7'h03,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd9));
        tbl.push_back(mk(0,0,1,1,7'h04,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd10));
        tbl.push_back(mk(0,0,1,1,7'h05,4'h0, 4'b0011,16'h0076,16'h0021, 0,4'd0,0,7'h00,0,8'h00, 0,1,4'd11));
        tbl.push_back(mk(0,0,1,1,7'h06,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd6,1,7'h01,1,8'h01, 0,1,4'd12));
        tbl.push_back(mk(0,1,1,1,7'h07,4'h0, 4'b0001,16'h0008,16'h000F, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0));
        tbl.push_back(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Fill all 16 entries from an empty ROB, then hold dispatch while full.
        for (int i = 0; i < 16; i++)
            run_vec(mk(0,0,1,1,7'(8'h40 + i),4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00,
                       0, (i == 15) ? 1'b0 : 1'b1, 4'((i + 1) % 16)), 100 + i);
        run_vec(mk(0,0,1,1,7'h5F,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,0,4'd0), 200);
        run_vec(mk(0,0,1,1,7'h5F,4'h0, 4'b0001,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,0,4'd0), 201);
        run_vec(mk(0,0,1,1,7'h5F,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd0,1,7'h40,1,8'h00, 0,1,4'd0), 202);
        run_vec(mk(0,0,1,1,7'h50,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,0,4'd1), 203);

        // Reset while a commit is registered and the next head is already done.
        run_vec(mk(0,0,0,0,7'h00,4'h0, 4'b0011,16'h0021,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 0,0,4'd1), 300);
        run_vec(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 1,4'd1,1,7'h41,1,8'h00, 0,1,4'd1), 301);
        run_vec(mk(1,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0), 302);
        run_vec(mk(0,0,0,0,7'h00,4'h0, 4'b0000,16'h0000,16'h0000, 0,4'd0,0,7'h00,0,8'h00, 1,1,4'd0), 303);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
